// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux block: slot state encoding,
// drop counter width and a bounded one-hot helper used by the decoder.
package stream_demux_pkg;

    typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

    localparam int DROP_CNT_W = 8;
    localparam int MAX_OUT    = 16;

    // Returns a one-hot vector for sel; all zeros when sel lies outside 0..n-1.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [3:0] sel, input int n);
        logic [MAX_OUT-1:0] vec;
        vec = '0;
        if (int'(sel) < n) begin
            vec[sel] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/stream_demux_onehot_decoder.sv
// Parametrised SEL_W -> NUM_OUT one-hot decoder with a valid qualifier;
// the generalised form of the old enable-gated 3-to-8 decoder.
module onehot_decoder
    import stream_demux_pkg::*;
#(
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               valid,
    output logic [NUM_OUT-1:0] onehot_out
);

    always_comb begin
        onehot_out = '0;
        if (valid) begin
            onehot_out = NUM_OUT'(onehot(4'(sel), NUM_OUT));
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with a single holding slot,
// global enable and out-of-range select dropping with a saturating drop count.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int NUM_OUT = 8,
    parameter  int DATA_W  = 8,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  bad_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_OUT);

    slot_state_t             state_q, state_d;
    logic [DATA_W-1:0]       data_q;
    logic [SEL_W-1:0]        dest_q;
    logic                    bad_q;
    logic [DROP_CNT_W-1:0]   drop_q;

    logic drain, accept, sel_ok, load, drop;

    onehot_decoder #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W)
    ) u_decoder (
        .sel        (dest_q),
        .valid      (state_q == S_FULL),
        .onehot_out (out_valid)
    );

    // out_valid is already gated by FULL, so any overlap with out_ready is the
    // selected channel taking the word.
    assign drain    = |(out_valid & out_ready);
    assign in_ready = rst_n & en & ((state_q == S_EMPTY) | drain);
    assign accept   = in_valid & in_ready;
    assign sel_ok   = {1'b0, in_sel} < SEL_LIMIT;

    always_comb begin
        state_d = state_q;
        load    = accept & sel_ok;
        drop    = accept & ~sel_ok;
        case (state_q)
            S_EMPTY: if (load) state_d = S_FULL;
            S_FULL:  if (drain && !load) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            dest_q  <= '0;
            bad_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            bad_q   <= drop;
            if (load) begin
                data_q <= in_data;
                dest_q <= in_sel;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign out_data = data_q;
    assign bad_sel  = bad_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Drives an 8-channel and a 6-channel stream_demux with identical stimulus and
// compares every cycle against a transaction-level model of each.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic [7:0] out_ready;

    logic       in_ready8, in_ready6;
    logic [7:0] out_valid8;
    logic [5:0] out_valid6;
    logic [7:0] out_data8, out_data6;
    logic       bad_sel8, bad_sel6;
    logic [7:0] drop_cnt8, drop_cnt6;

    int errors = 0;
    int checks = 0;

    // model state per DUT: index 0 = 8 channels, index 1 = 6 channels
    int         nout[2] = '{8, 6};
    bit         m_full[2];
    int         m_dest[2];
    logic [7:0] m_data[2];
    int         m_drop[2];
    bit         m_bad[2];

    always #5 clk = ~clk;

    stream_demux #(.NUM_OUT(8), .DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .bad_sel(bad_sel8), .drop_cnt(drop_cnt8)
    );

    stream_demux #(.NUM_OUT(6), .DATA_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid6), .out_ready(out_ready[5:0]),
        .out_data(out_data6), .bad_sel(bad_sel6), .drop_cnt(drop_cnt6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 1'b0;
            m_dest[d] = 0;
            m_data[d] = 8'h00;
            m_drop[d] = 0;
            m_bad[d]  = 1'b0;
        end
    endtask

    function automatic bit exp_ready(input int d);
        return rst_n && en && (!m_full[d] || out_ready[m_dest[d]]);
    endfunction

    // Check both DUTs against the model, then advance one clock edge.
    task automatic cycle();
        logic [7:0] ev;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev = m_full[d] ? (8'h01 << m_dest[d]) : 8'h00;
            if (d == 0) begin
                chk("in_ready8",  32'(in_ready8),  32'(exp_ready(0)));
                chk("out_valid8", 32'(out_valid8), 32'(ev));
                chk("out_data8",  32'(out_data8),  32'(m_data[0]));
                chk("bad_sel8",   32'(bad_sel8),   32'(m_bad[0]));
                chk("drop_cnt8",  32'(drop_cnt8),  32'(m_drop[0]));
            end else begin
                chk("in_ready6",  32'(in_ready6),  32'(exp_ready(1)));
                chk("out_valid6", 32'(out_valid6), 32'(ev[5:0]));
                chk("out_data6",  32'(out_data6),  32'(m_data[1]));
                chk("bad_sel6",   32'(bad_sel6),   32'(m_bad[1]));
                chk("drop_cnt6",  32'(drop_cnt6),  32'(m_drop[1]));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit acc, drained;
                acc     = in_valid && exp_ready(d);
                drained = m_full[d] && out_ready[m_dest[d]];
                m_bad[d] = 1'b0;
                if (acc && int'(in_sel) < nout[d]) begin
                    m_full[d] = 1'b1;
                    m_dest[d] = int'(in_sel);
                    m_data[d] = in_data;
                end else begin
                    if (acc) begin
                        m_bad[d]  = 1'b1;
                        m_drop[d] = (m_drop[d] == 255) ? 255 : m_drop[d] + 1;
                    end
                    if (drained) m_full[d] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int sel, input logic [7:0] data);
        in_valid = v;
        in_sel   = 3'(sel);
        in_data  = data;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; out_ready = 8'hFF;
        drive(1, 0, 8'h00);
        model_reset();
        @(posedge clk); #1;

        // reset held with in_valid asserted, then release idle
        repeat (2) cycle();
        rst_n = 1'b1; drive(0, 0, 8'h00);
        repeat (2) cycle();

        // single route to channel 5
        drive(1, 5, 8'hA5); cycle();
        drive(0, 0, 8'h00); cycle();
        chk("route_ch5", 32'(out_valid8), 32'h0000_0000);
        cycle();

        // backpressure on channel 2
        out_ready = 8'hFB;
        drive(1, 2, 8'h11); cycle();
        drive(1, 2, 8'h22);
        repeat (4) cycle();
        chk("stall_hold", 32'({out_valid8[2], out_data8}), 32'h0000_0111);
        out_ready = 8'hFF; cycle();
        drive(0, 0, 8'h00); repeat (2) cycle();

        // streaming, channels cycling 0..7
        for (int i = 0; i < 16; i++) begin
            drive(1, i % 8, 8'(8'h40 + i));
            cycle();
        end
        drive(0, 0, 8'h00); repeat (2) cycle();

        // enable gating with a word held in channel 3
        out_ready = 8'hF7;
        drive(1, 3, 8'h33); cycle();
        en = 1'b0; drive(1, 4, 8'h44);
        repeat (2) cycle();
        out_ready = 8'hFF;
        repeat (2) cycle();
        en = 1'b1; cycle();
        drive(0, 0, 8'h00); repeat (2) cycle();

        // bad selects after a fresh reset
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 8'(8'hE0 + i)); cycle();
        end
        drive(1, 1, 8'h3C); cycle();
        drive(0, 0, 8'h00); cycle();
        chk("drop3_ch6", 32'(drop_cnt6), 32'd3);
        cycle();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            out_ready = 8'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), 8'($urandom));
            cycle();
        end

        // reset mid-operation with a word stuck in the slot
        out_ready = 8'h00; en = 1'b1;
        drive(1, 4, 8'h5A); repeat (2) cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        out_ready = 8'hFF;
        drive(0, 0, 8'h00); cycle();

        // drop counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, 7, 8'(i)); cycle();
        end
        drive(0, 0, 8'h00); cycle();
        chk("drop_sat6", 32'(drop_cnt6), 32'd255);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-NUM_OUT demultiplexer for valid/ready streams; successor to the combinational 3-to-8 enable-gated demux.
- Routes each accepted input word to the output channel selected by in_sel through one holding register with backpressure, a global enable and out-of-range select detection.
- Sits between a single producer and NUM_OUT independent consumers.

Parameters:
- NUM_OUT, 8, number of output channels (2..16).
- DATA_W, 8, data word width in bits.
- SEL_W, $clog2(NUM_OUT), select width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  global enable; 0 blocks new input acceptance.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NUM_OUT  one-hot, channel i holds a word.
- out_ready  input  NUM_OUT  per-channel consumer ready.
- out_data  output  DATA_W  shared data bus, valid for the channel whose out_valid bit is set.
- bad_sel  output  1  one-cycle pulse: a word with in_sel >= NUM_OUT was dropped.
- drop_cnt  output  8  saturating count of dropped words.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge): slot EMPTY, out_valid=0, out_data=0, bad_sel=0, drop_cnt=0. in_ready=0 while rst_n=0.
- Holding slot FSM, states EMPTY and FULL. The slot holds data_q and dest_q.
- Drain: drain = FULL & out_ready[dest_q].
- in_ready = rst_n & en & (EMPTY | drain). This is combinational from state, en and out_ready. It never depends on in_valid.
- Accept: accept = in_valid & in_ready.
- In-range accept (in_sel < NUM_OUT): on the next edge, the slot goes to or stays FULL, data_q=in_data, dest_q=in_sel. Latency is 1 cycle from accept to out_valid.
- Out-of-range accept (in_sel >= NUM_OUT, only possible when NUM_OUT is not a power of 2):
  - The word is consumed and discarded; the slot is not loaded.
  - bad_sel=1 on the next cycle only.
  - drop_cnt increments by 1 and saturates at 255.
- Drain without accept: FULL -> EMPTY.
- Drain with in-range accept on the same edge: the slot stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle.
- Outputs:
  - out_valid = FULL ? (1 << dest_q) : 0. At most one bit is set.
  - out_data = data_q. It holds its value while FULL and !drain.
- Stability: while FULL and out_ready[dest_q]=0, data_q, dest_q and out_valid are held. out_ready on non-selected channels has no effect.
- en=0: no new accepts. A word already in the slot still drains normally. en has no effect on reset behaviour.
- Reset mid-operation: the word in the slot is discarded without a drain handshake, and drop_cnt clears.
- X-safety: in_data and in_sel are sampled only on accept.

Decomposition:
- Package stream_demux_pkg:
  - typedef enum logic {S_EMPTY, S_FULL} slot_state_t
  - localparam DROP_CNT_W = 8
  - function onehot(sel, n) returning a NUM_OUT-bit one-hot vector.
- Sub-module onehot_decoder:
  - Parametrised SEL_W -> NUM_OUT decoder with a valid qualifier.
  - Used to generate out_valid from dest_q and FULL.
  - Generalises the existing 3-to-8 decoder.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1, then release with en=1 and in_valid=0. Required: out_valid=0, drop_cnt=0, in_ready=0 during reset, in_ready=1 after release.
- Single route (NUM_OUT=8, all out_ready=1): in_data=0xA5, in_sel=5. Required: next cycle out_valid=8'b0010_0000, out_data=0xA5; slot EMPTY the cycle after.
- Backpressure: send 0x11 to ch2 with out_ready[2]=0 for 4 cycles, then send a second word 0x22. Required:
  - out_valid[2]=1 and out_data=0x11 held for all 4 cycles.
  - in_ready=0 during the stall.
  - Raising out_ready[2] accepts 0x22 on the same edge.
- Streaming: 16 consecutive words to channels 0..7 cycling, with all out_ready=1. Required: 1 word/cycle, in_ready constantly 1, order and channel mapping preserved.
- Enable gating: word held in ch3 with en=0 and in_valid=1. Required: in_ready=0, the ch3 word still drains when out_ready[3]=1, and no new accept until en=1.
- Bad select (NUM_OUT=6): send in_sel=7 three times, then in_sel=1 with data 0x3C. Required:
  - bad_sel pulses 3 times and drop_cnt=3.
  - No out_valid for the dropped words.
  - Channel 1 receives 0x3C.
  - A separate run confirms drop_cnt saturates at 255 after 300 drops.
